// File: rtl/ifetch_unit_pkg.sv
// Shared types for the instruction fetch front end: bus structs, queue entry and FSM state.
package ifetch_unit_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_q_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_DISCARD
  } fetch_state_t;

  localparam logic [63:0] INSTR_BYTES = 64'd4;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} pairs; head is read straight from the entry registers.
module fetch_queue
  import ifetch_unit_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  fetch_q_entry_t   entry_i,
  output fetch_q_entry_t   entry_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fetch_q_entry_t   mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign entry_o = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_q[gi] <= '0;
        end else if (do_push && !flush_i && wr_ptr_q == PTR_W'(gi)) begin
          mem_q[gi] <= entry_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: owns fetch PC and ibus handshake, queues returned words for decode,
// and drops responses belonging to a path abandoned by a redirect.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [63:0]      hold_addr_q, hold_addr_d;
  logic             q_push, q_pop, q_flush, q_full, q_empty;
  logic [CNT_W-1:0] q_count, count_after;
  fetch_q_entry_t   q_head, q_entry;
  logic             unused_addr_ok;

  assign unused_addr_ok = iresp.addr_ok;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (q_flush),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .entry_i (q_entry),
    .entry_o (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign out_valid = ~q_empty;
  assign out_pc    = q_head.pc;
  assign out_instr = q_head.instr;
  assign q_entry   = '{pc: fetch_pc_q, instr: iresp.data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FS_IDLE;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    ireq        = '0;
    q_flush     = redirect_valid;
    q_pop       = out_valid & out_ready & ~redirect_valid;
    q_push      = (state_q == FS_REQ) & iresp.data_ok & ~redirect_valid;
    count_after = q_count + CNT_W'(q_push) - CNT_W'(q_pop);

    case (state_q)
      FS_IDLE: begin
        if (!q_full) state_d = FS_REQ;
      end
      FS_REQ: begin
        ireq.valid = 1'b1;
        ireq.addr  = fetch_pc_q;
        if (iresp.data_ok) begin
          fetch_pc_d = fetch_pc_q + INSTR_BYTES;
          state_d    = (count_after < CNT_W'(QDEPTH)) ? FS_REQ : FS_IDLE;
        end
      end
      FS_DISCARD: begin
        // The abandoned request stays on the bus until it completes.
        ireq.valid = 1'b1;
        ireq.addr  = hold_addr_q;
        if (iresp.data_ok) state_d = FS_REQ;
      end
      default: state_d = FS_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      case (state_q)
        FS_IDLE: state_d = FS_REQ;
        FS_REQ: begin
          if (iresp.data_ok) begin
            state_d = FS_REQ;
          end else begin
            state_d     = FS_DISCARD;
            hold_addr_d = fetch_pc_q;
          end
        end
        FS_DISCARD: state_d = iresp.data_ok ? FS_REQ : FS_DISCARD;
        default:    state_d = FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural ibus with programmable latency, vector table, and a
// scoreboard of the {pc, instr} pairs decode is expected to receive.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  ifetch_unit #(.RESET_PC(64'h8000_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat = 0;
  int wait_cnt = 0;
  logic        prev_pending = 1'b0;
  logic [63:0] prev_addr = '0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        new_test;
    logic        rdy;
    logic        exp_vld;
    logic [63:0] exp_addr;
    logic        exp_ov;
    logic [63:0] exp_opc;
    logic        push_exp;
    logic [63:0] push_pc;
  } vec_t;
  localparam int NV = 14;
  vec_t vecs[NV];

  localparam logic [63:0] B = 64'h8000_0000;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = instr_of(pc);
    sb_q.push_back(e);
  endtask

  task automatic sb_done(input string name);
    chk({name, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  // One clock: bus answers the visible request, inputs are driven, handshake is scored.
  task automatic step(input logic rdy, input logic redir, input logic [63:0] rpc);
    exp_t e;
    if (prev_pending) begin
      chk("bus_hold_valid", 64'(ireq.valid), 64'd1);
      chk("bus_hold_addr", ireq.addr, prev_addr);
    end
    iresp.addr_ok = ireq.valid;
    iresp.data_ok = 1'b0;
    iresp.data    = 32'h0;
    if (ireq.valid) begin
      if (wait_cnt >= lat) begin
        iresp.data_ok = 1'b1;
        iresp.data    = instr_of(ireq.addr);
        wait_cnt      = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (out_valid && rdy && !redir) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h expected no handshake", out_pc);
      end else begin
        e = sb_q.pop_front();
        $display("pop pc=%h instr=%h", out_pc, out_instr);
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", 64'(out_instr), 64'(e.instr));
      end
    end
    prev_pending = ireq.valid & ~iresp.data_ok;
    prev_addr    = ireq.addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    iresp          = '0;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    prev_pending = 1'b0;
    wait_cnt     = 0;
    sb_q.delete();
    chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
    chk("rst_ireq_addr", ireq.addr, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
  endtask

  task automatic expect_bus(input string name, input logic [63:0] addr, input logic ov);
    chk({name, "_valid"}, 64'(ireq.valid), 64'd1);
    chk({name, "_addr"}, ireq.addr, addr);
    chk({name, "_out_valid"}, 64'(out_valid), 64'(ov));
  endtask

  initial begin
    // Zero-latency streaming with decode always ready.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'd0,     1'b0, 64'd0,     1'b0, 64'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, B,         1'b0, 64'd0,     1'b1, B};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, B + 4,     1'b1, B,         1'b1, B + 4};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, B + 8,     1'b1, B + 4,     1'b1, B + 8};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, B + 12,    1'b1, B + 8,     1'b1, B + 12};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, B + 16,    1'b1, B + 12,    1'b0, 64'd0};
    // Back-pressure: queue fills, fetch idles, one pop restarts it at +8.
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 64'd0,     1'b0, 64'd0,     1'b0, 64'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, B,         1'b0, 64'd0,     1'b1, B};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, B + 4,     1'b1, B,         1'b0, 64'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, B,         1'b0, 64'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 64'd0,     1'b1, B,         1'b0, 64'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, B + 4,     1'b0, 64'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, B + 8,     1'b1, B + 4,     1'b0, 64'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, B + 4,     1'b0, 64'd0};

    lat = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].new_test) begin
        if (i > 0) sb_done("table");
        do_reset();
      end
      chk($sformatf("v%0d_valid", i), 64'(ireq.valid), 64'(vecs[i].exp_vld));
      chk($sformatf("v%0d_addr", i), ireq.addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].exp_opc);
      if (vecs[i].push_exp) sb_push(vecs[i].push_pc);
      step(vecs[i].rdy, 1'b0, 64'd0);
    end
    sb_done("table");

    // Redirect during a slow request: stale response dropped, address held until data_ok.
    do_reset();
    lat = 0;
    step(1'b1, 1'b0, 64'd0);
    sb_push(B);      step(1'b1, 1'b0, 64'd0);
    sb_push(B + 4);  step(1'b1, 1'b0, 64'd0);
    sb_push(B + 8);  step(1'b1, 1'b0, 64'd0);
    step(1'b1, 1'b0, 64'd0);
    expect_bus("t3_c5", B + 16, 1'b1);
    lat = 3;
    step(1'b1, 1'b1, B + 64'h100);
    for (int c = 6; c <= 8; c++) begin
      expect_bus($sformatf("t3_c%0d", c), B + 16, 1'b0);
      step(1'b1, 1'b0, 64'd0);
    end
    sb_push(B + 64'h100);
    for (int c = 9; c <= 12; c++) begin
      expect_bus($sformatf("t3_c%0d", c), B + 64'h100, 1'b0);
      step(1'b1, 1'b0, 64'd0);
    end
    chk("t3_head_valid", 64'(out_valid), 64'd1);
    chk("t3_head_pc", out_pc, B + 64'h100);
    step(1'b1, 1'b0, 64'd0);
    sb_done("t3");

    // Redirect coinciding with data_ok while entries are queued.
    do_reset();
    lat = 0;
    step(1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 64'd0);
    expect_bus("t4_c2", B + 4, 1'b1);
    step(1'b0, 1'b1, B + 64'h200);
    expect_bus("t4_c3", B + 64'h200, 1'b0);
    sb_push(B + 64'h200);
    step(1'b1, 1'b0, 64'd0);
    chk("t4_head_pc", out_pc, B + 64'h200);
    step(1'b1, 1'b0, 64'd0);
    sb_done("t4");

    // Two redirects while discarding: only the second target is fetched.
    do_reset();
    lat = 3;
    step(1'b1, 1'b0, 64'd0);
    expect_bus("t5_c1", B, 1'b0);
    step(1'b1, 1'b1, B + 64'h300);
    expect_bus("t5_c2", B, 1'b0);
    step(1'b1, 1'b1, B + 64'h400);
    for (int c = 3; c <= 4; c++) begin
      expect_bus($sformatf("t5_c%0d", c), B, 1'b0);
      step(1'b1, 1'b0, 64'd0);
    end
    sb_push(B + 64'h400);
    for (int c = 5; c <= 8; c++) begin
      expect_bus($sformatf("t5_c%0d", c), B + 64'h400, 1'b0);
      step(1'b1, 1'b0, 64'd0);
    end
    chk("t5_head_valid", 64'(out_valid), 64'd1);
    chk("t5_head_pc", out_pc, B + 64'h400);
    step(1'b1, 1'b0, 64'd0);
    sb_done("t5");

    // Reset while a request is outstanding and an entry is queued.
    do_reset();
    lat = 0;
    step(1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 64'd0);
    expect_bus("t6_c2", B + 4, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 64'd0);
    expect_bus("t6_restart", B, 1'b0);
    sb_push(B);
    step(1'b1, 1'b0, 64'd0);
    chk("t6_head_pc", out_pc, B);
    step(1'b1, 1'b0, 64'd0);
    sb_done("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
